bus_slot_arbiter: RTL and testbench

Owns the 2 MHz system bus cycle derived from the 16 MHz clk. Generates phi2 and an 8-phase counter. Shares each bus cycle between the CPU and two secondary masters:
- Requester A: floppy DMA, which may be urgent.
- Requester B: debug/monitor port.

The phi1 half-cycle is free for secondary masters. The phi2 half-cycle belongs to the CPU unless A steals it, in which case cpu_rdy is withheld.

---
 rtl/bus_slot_pkg.sv | 24 ++
 rtl/bus_phase_counter.sv | 31 +++
 rtl/bus_slot_arbiter.sv | 93 +++++++++
 tb/tb_bus_slot_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_slot_pkg.sv
// Shared encodings for the bus slot arbiter: slot owners, round-robin pointer
// and the bus phases at which slots start and decisions are taken.
package bus_slot_pkg;

  typedef enum logic [1:0] {
    OWN_CPU  = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10,
    OWN_IDLE = 2'b11
  } owner_e;

  typedef enum logic {
    RrA = 1'b0,
    RrB = 1'b1
  } rr_e;

  localparam logic [2:0] PH_PHI1   = 3'd0;
  localparam logic [2:0] PH_PHI2   = 3'd4;
  localparam logic [2:0] PH_DECIDE = 3'd7;

  // Last phase of the phi1 half; the phi2 slot is resolved on the edge leaving it.
  localparam logic [2:0] PH_PHI1_LAST = PH_PHI2 - 3'd1;

endpackage

// File: rtl/bus_phase_counter.sv
// 8-phase bus cycle counter: phase 0..7 with phi2 high for phases 4..7 and
// a slot_start pulse at the start of each half-cycle. All outputs registered.
module bus_phase_counter
  import bus_slot_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] phase,
  output logic       phi2,
  output logic       slot_start
);

  logic [2:0] phase_d;

  always_comb begin
    phase_d = phase + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_PHI1;
      phi2       <= 1'b0;
      slot_start <= 1'b0;
    end else begin
      phase      <= phase_d;
      phi2       <= phase_d[2];
      slot_start <= (phase_d == PH_PHI1) || (phase_d == PH_PHI2);
    end
  end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Shares each 2 MHz bus cycle between the CPU and two secondary masters:
// phi1 slot round-robins A/B, phi2 slot is the CPU's unless urgent A steals it.
module bus_slot_arbiter
  import bus_slot_pkg::*;
#(
  parameter int unsigned MAX_STEAL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       urgent_a,
  input  logic       req_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic [1:0] slot_owner,
  output logic       slot_start,
  output logic [2:0] phase,
  output logic       phi2,
  output logic       cpu_rdy
);

  localparam logic [2:0] MaxSteal = 3'(MAX_STEAL);

  owner_e     slot_owner_q;
  owner_e     own1_d;
  owner_e     own2_q;
  rr_e        rr_q;
  rr_e        rr_d;
  logic [2:0] steal_cnt_q;
  logic       steal_d;

  bus_phase_counter u_phase (
    .clk        (clk),
    .rst        (rst),
    .phase      (phase),
    .phi2       (phi2),
    .slot_start (slot_start)
  );

  assign slot_owner = slot_owner_q;

  // Decision inputs; only consumed on the phase-7 edge.
  always_comb begin
    own1_d = OWN_IDLE;
    rr_d   = rr_q;
    if (req_a && req_b) begin
      own1_d = (rr_q == RrA) ? OWN_A : OWN_B;
      rr_d   = (rr_q == RrA) ? RrB : RrA;
    end else if (req_a) begin
      own1_d = OWN_A;
    end else if (req_b) begin
      own1_d = OWN_B;
    end
    steal_d = req_a && urgent_a && (steal_cnt_q < MaxSteal);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      slot_owner_q <= OWN_IDLE;
      own2_q       <= OWN_IDLE;
      cpu_rdy      <= 1'b1;
      rr_q         <= RrA;
      steal_cnt_q  <= 3'd0;
    end else begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      if (phase == PH_DECIDE) begin
        slot_owner_q <= own1_d;
        gnt_a        <= (own1_d == OWN_A);
        gnt_b        <= (own1_d == OWN_B);
        own2_q       <= steal_d ? OWN_A : OWN_CPU;
        cpu_rdy      <= !steal_d;
        steal_cnt_q  <= steal_d ? steal_cnt_q + 3'd1 : 3'd0;
        rr_q         <= rr_d;
      end else if (phase == PH_PHI1_LAST) begin
        // A stolen slot whose request has since dropped goes idle; cpu_rdy stays low.
        if (own2_q == OWN_A) begin
          if (req_a) begin
            slot_owner_q <= OWN_A;
            gnt_a        <= 1'b1;
          end else begin
            slot_owner_q <= OWN_IDLE;
          end
        end else begin
          slot_owner_q <= own2_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// Scenario bench for bus_slot_arbiter; grants are checked against a scoreboard
// of expected (requester, phase) pulses queued as each scenario is driven.
module tb_bus_slot_arbiter;

  typedef struct packed {
    logic       is_a;
    logic [2:0] ph;
  } gnt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a;
  logic       urgent_a;
  logic       req_b;
  logic       gnt_a;
  logic       gnt_b;
  logic [1:0] slot_owner;
  logic       slot_start;
  logic [2:0] phase;
  logic       phi2;
  logic       cpu_rdy;

  int   n_checks = 0;
  int   n_fail   = 0;
  gnt_t exp_q[$];
  gnt_t mon_got;
  gnt_t mon_want;

  bus_slot_arbiter #(
    .MAX_STEAL (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .urgent_a   (urgent_a),
    .req_b      (req_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .slot_owner (slot_owner),
    .slot_start (slot_start),
    .phase      (phase),
    .phi2       (phi2),
    .cpu_rdy    (cpu_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Grant monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (gnt_a || gnt_b) begin
      n_checks++;
      mon_got.is_a = gnt_a;
      mon_got.ph   = phase;
      if (gnt_a && gnt_b) begin
        n_fail++;
        $display("FAIL gnt_both: got gnt_a=1 gnt_b=1 at phase %0d, want at most one", phase);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL gnt_unexpected: got gnt_a=%0b gnt_b=%0b at phase %0d, want none",
                 gnt_a, gnt_b, phase);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_fail++;
          $display("FAIL gnt_order: got is_a=%0b phase=%0d, want is_a=%0b phase=%0d",
                   mon_got.is_a, mon_got.ph, mon_want.is_a, mon_want.ph);
        end
      end
    end
  end

  function automatic gnt_t mk(input logic is_a, input logic [2:0] ph);
    gnt_t g;
    g.is_a = is_a;
    g.ph   = ph;
    return g;
  endfunction

  task automatic goto_phase(input logic [2:0] p);
    bit found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (phase == p) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL goto_phase: got phase %0d, want %0d within 16 clks", phase, p);
    end
  endtask

  task automatic test_reset();
    logic [2:0] e;
    rst = 1'b1;
    req_a = 1'b0;
    urgent_a = 1'b0;
    req_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({phase, phi2, cpu_rdy, slot_owner, gnt_a, gnt_b, slot_start} !== {3'd0, 1'b0, 1'b1,
        2'b11, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got phase=%0d phi2=%0b rdy=%0b own=%b ga=%0b gb=%0b ss=%0b, want 0 0 1 11 0 0 0",
               phase, phi2, cpu_rdy, slot_owner, gnt_a, gnt_b, slot_start);
    end
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      e = 3'(i % 8);
      n_checks++;
      if ({phase, phi2, slot_start} !== {e, (e >= 3'd4), (e == 3'd0 || e == 3'd4)}) begin
        n_fail++;
        $display("FAIL reset_count: got phase=%0d phi2=%0b ss=%0b, want phase=%0d phi2=%0b ss=%0b",
                 phase, phi2, slot_start, e, (e >= 3'd4), (e == 3'd0 || e == 3'd4));
      end
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b11, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_idle: got own=%b rdy=%0b at phase %0d, want own=11 rdy=1",
                 slot_owner, cpu_rdy, phase);
      end
    end
  endtask

  task automatic test_req_b_only();
    goto_phase(3'd6);
    req_b = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back(mk(1'b0, 3'd0));
    for (int c = 0; c < 4; c++) begin
      goto_phase(3'd0);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b10, 1'b1}) begin
        n_fail++;
        $display("FAIL b_phi1: got own=%b rdy=%0b, want own=10 rdy=1", slot_owner, cpu_rdy);
      end
      goto_phase(3'd4);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL b_phi2: got own=%b rdy=%0b, want own=00 rdy=1", slot_owner, cpu_rdy);
      end
      goto_phase(3'd6);
      if (c == 3) req_b = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want_own;
    goto_phase(3'd6);
    req_a = 1'b1;
    req_b = 1'b1;
    for (int c = 0; c < 4; c++) exp_q.push_back(mk((c % 2) == 0, 3'd0));
    for (int c = 0; c < 4; c++) begin
      want_own = ((c % 2) == 0) ? 2'b01 : 2'b10;
      goto_phase(3'd0);
      n_checks++;
      if (slot_owner !== want_own) begin
        n_fail++;
        $display("FAIL rr_phi1: cycle %0d got own=%b, want own=%b", c, slot_owner, want_own);
      end
      goto_phase(3'd4);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b00, 1'b1}) begin
        n_fail++;
        $display("FAIL rr_phi2: cycle %0d got own=%b rdy=%0b, want own=00 rdy=1",
                 c, slot_owner, cpu_rdy);
      end
      goto_phase(3'd6);
      if (c == 3) begin
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
  endtask

  // Entered at phase 6 with req_a/urgent_a already high; drops them on the last cycle.
  task automatic steal_burst(input int n, input logic [7:0] stolen);
    for (int c = 0; c < n; c++) begin
      exp_q.push_back(mk(1'b1, 3'd0));
      if (stolen[c]) exp_q.push_back(mk(1'b1, 3'd4));
      goto_phase(3'd0);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b01, !stolen[c]}) begin
        n_fail++;
        $display("FAIL steal_phi1: cycle %0d got own=%b rdy=%0b, want own=01 rdy=%0b",
                 c, slot_owner, cpu_rdy, !stolen[c]);
      end
      goto_phase(3'd4);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {(stolen[c] ? 2'b01 : 2'b00), !stolen[c]}) begin
        n_fail++;
        $display("FAIL steal_phi2: cycle %0d got own=%b rdy=%0b, want own=%b rdy=%0b",
                 c, slot_owner, cpu_rdy, (stolen[c] ? 2'b01 : 2'b00), !stolen[c]);
      end
      goto_phase(3'd6);
      n_checks++;
      if (cpu_rdy !== !stolen[c]) begin
        n_fail++;
        $display("FAIL steal_rdy_hold: cycle %0d got rdy=%0b, want %0b", c, cpu_rdy, !stolen[c]);
      end
      if (c == n - 1) begin
        req_a = 1'b0;
        urgent_a = 1'b0;
      end
    end
  endtask

  task automatic test_steal_limit();
    goto_phase(3'd6);
    req_a = 1'b1;
    urgent_a = 1'b1;
    steal_burst(8, 8'b0111_0111);
  endtask

  task automatic test_dropped_steal();
    goto_phase(3'd6);
    req_a = 1'b1;
    urgent_a = 1'b1;
    exp_q.push_back(mk(1'b1, 3'd0));
    goto_phase(3'd0);
    n_checks++;
    if ({slot_owner, cpu_rdy} !== {2'b01, 1'b0}) begin
      n_fail++;
      $display("FAIL drop_phi1: got own=%b rdy=%0b, want own=01 rdy=0", slot_owner, cpu_rdy);
    end
    goto_phase(3'd2);
    req_a = 1'b0;
    urgent_a = 1'b0;
    for (int p = 4; p <= 6; p++) begin
      goto_phase(3'(p));
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b11, 1'b0}) begin
        n_fail++;
        $display("FAIL drop_phi2: phase %0d got own=%b rdy=%0b, want own=11 rdy=0",
                 p, slot_owner, cpu_rdy);
      end
    end
    // One steal already counted, so only two more fit before a forced CPU cycle.
    req_a = 1'b1;
    urgent_a = 1'b1;
    steal_burst(3, 8'b0000_0011);
  endtask

  task automatic test_reset_mid_cycle();
    goto_phase(3'd6);
    req_a = 1'b1;
    urgent_a = 1'b1;
    exp_q.push_back(mk(1'b1, 3'd0));
    exp_q.push_back(mk(1'b1, 3'd4));
    goto_phase(3'd0);
    n_checks++;
    if (cpu_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pre: got rdy=%0b, want 0", cpu_rdy);
    end
    goto_phase(3'd5);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({phase, cpu_rdy, slot_owner, gnt_a, gnt_b} !== {3'd0, 1'b1, 2'b11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got phase=%0d rdy=%0b own=%b ga=%0b gb=%0b, want 0 1 11 0 0",
               phase, cpu_rdy, slot_owner, gnt_a, gnt_b);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({slot_owner, cpu_rdy} !== {2'b11, 1'b1}) begin
        n_fail++;
        $display("FAIL mid_idle: phase %0d got own=%b rdy=%0b, want own=11 rdy=1",
                 phase, slot_owner, cpu_rdy);
      end
    end
    // steal_cnt was cleared, so a full run of three steals is available again.
    steal_burst(4, 8'b0000_0111);
  endtask

  initial begin
    test_reset();
    test_req_b_only();
    test_round_robin();
    test_steal_limit();
    test_dropped_steal();
    test_reset_mid_cycle();
    goto_phase(3'd6);
    goto_phase(3'd6);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL gnt_missing: got %0d expected grants never seen, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
